// File: rtl/flash_page_cache_if.sv
// Host-side and SPI-side signal bundle for the flash page cache.
interface flash_page_cache_if;
   logic [23:0] address_i;
   logic        enable_i;
   logic [7:0]  data_out_o;
   logic        busy_o;
   logic        spi_cs_o;
   logic        spi_clk_o;
   logic        spi_do_o;
   logic        spi_di_i;
   logic        flash_reset_o;
   logic        flash_wp_o;

   modport slave (
      input  address_i, enable_i, spi_di_i,
      output data_out_o, busy_o, spi_cs_o, spi_clk_o, spi_do_o, flash_reset_o, flash_wp_o
   );

   modport master (
      output address_i, enable_i, spi_di_i,
      input  data_out_o, busy_o, spi_cs_o, spi_clk_o, spi_do_o, flash_reset_o, flash_wp_o
   );
endinterface

// File: rtl/flash_page_cache.sv
// Page cache in front of a mode-0 SPI NOR flash: resident pages are read in one
// cycle, misses fetch a whole page with a read command into a round-robin victim.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | serve hits, launch a fill on an enabled miss
// CMD     | load next command byte into the shifter
// OUT_LO  | command bit on spi_do, spi_clk low
// OUT_HI  | spi_clk high, flash samples the command bit
// IN_LO   | spi_clk low; leaving it raises spi_clk and samples spi_di
// IN_HI   | spi_clk high
// STORE   | write assembled byte into the victim slot
// FINISH  | tag and validate the victim, release chip select
module flash_page_cache #(
   parameter int PAGE_BITS = 12,
   parameter int SLOTS     = 2,
   parameter int CLK_DIV   = 1,
   parameter int FAST_READ = 0
) (
   input logic                clk,
   input logic                reset,
   flash_page_cache_if.slave  bus
);
   localparam int SW = (SLOTS > 1) ? $clog2(SLOTS) : 1;
   localparam int NS = 1 << SW;
   localparam int TW = 24 - PAGE_BITS;
   localparam logic [7:0] OPCODE = (FAST_READ != 0) ? 8'h0B : 8'h03;
   localparam logic [2:0] N_CMD  = (FAST_READ != 0) ? 3'd5 : 3'd4;
   localparam logic [3:0] DIV_RELOAD = 4'(CLK_DIV - 1);
   localparam logic [PAGE_BITS-1:0] CNT_LAST = '1;

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_OUT_LO = 3'd2;
   localparam logic [2:0] S_OUT_HI = 3'd3;
   localparam logic [2:0] S_IN_LO  = 3'd4;
   localparam logic [2:0] S_IN_HI  = 3'd5;
   localparam logic [2:0] S_STORE  = 3'd6;
   localparam logic [2:0] S_FINISH = 3'd7;

   logic [7:0]           mem_q [0:(1 << (SW + PAGE_BITS)) - 1];
   logic [TW-1:0]        tags_q [NS], tags_d [NS];
   logic [NS-1:0]        valid_q, valid_d;
   logic [SW-1:0]        ptr_q, ptr_d, victim_q, victim_d;
   logic [TW-1:0]        fill_tag_q, fill_tag_d;
   logic [2:0]           state_q, state_d;
   logic [3:0]           div_q, div_d;
   logic [2:0]           bit_q, bit_d;
   logic [2:0]           cmd_idx_q, cmd_idx_d;
   logic [7:0]           shift_q, shift_d;
   logic [PAGE_BITS-1:0] byte_cnt_q, byte_cnt_d;
   logic [7:0]           data_out_q, data_out_d;
   logic                 busy_q, busy_d, cs_q, cs_d, sclk_q, sclk_d, sdo_q, sdo_d;

   logic [TW-1:0]  addr_tag;
   logic [23:0]    fill_addr;
   logic           hit;
   logic [SW-1:0]  hit_slot;
   logic [7:0]     cmd_byte;

   assign addr_tag  = bus.address_i[23:PAGE_BITS];
   assign fill_addr = {fill_tag_q, {PAGE_BITS{1'b0}}};

   // Tag lookup across all slots; tags are unique so at most one matches.
   always_comb begin
      hit      = 1'b0;
      hit_slot = '0;
      for (int s = 0; s < NS; s++) begin
         if (valid_q[s] && tags_q[s] == addr_tag) begin
            hit      = 1'b1;
            hit_slot = SW'(s);
         end
      end
   end

   // Command byte sequence: opcode, page-aligned address, optional dummy.
   always_comb begin
      case (cmd_idx_q)
         3'd0:    cmd_byte = OPCODE;
         3'd1:    cmd_byte = fill_addr[23:16];
         3'd2:    cmd_byte = fill_addr[15:8];
         3'd3:    cmd_byte = fill_addr[7:0];
         default: cmd_byte = 8'h00;
      endcase
   end

   // Next-state logic for the fill sequencer and the hit path.
   always_comb begin
      state_d    = state_q;
      tags_d     = tags_q;
      valid_d    = valid_q;
      ptr_d      = ptr_q;
      victim_d   = victim_q;
      fill_tag_d = fill_tag_q;
      div_d      = div_q;
      bit_d      = bit_q;
      cmd_idx_d  = cmd_idx_q;
      shift_d    = shift_q;
      byte_cnt_d = byte_cnt_q;
      data_out_d = data_out_q;
      busy_d     = busy_q;
      cs_d       = cs_q;
      sclk_d     = sclk_q;
      sdo_d      = sdo_q;
      case (state_q)
         S_IDLE: begin
            if (hit) begin
               busy_d     = 1'b0;
               data_out_d = mem_q[{hit_slot, bus.address_i[PAGE_BITS-1:0]}];
            end else begin
               busy_d = 1'b1;
               if (bus.enable_i) begin
                  fill_tag_d     = addr_tag;
                  victim_d       = ptr_q;
                  valid_d[ptr_q] = 1'b0;
                  cs_d           = 1'b0;
                  cmd_idx_d      = 3'd0;
                  state_d        = S_CMD;
               end
            end
         end
         S_CMD: begin
            shift_d   = cmd_byte;
            sdo_d     = cmd_byte[7];
            bit_d     = 3'd7;
            div_d     = DIV_RELOAD;
            cmd_idx_d = cmd_idx_q + 3'd1;
            state_d   = S_OUT_LO;
         end
         S_OUT_LO: begin
            if (div_q == 4'd0) begin
               sclk_d  = 1'b1;
               div_d   = DIV_RELOAD;
               state_d = S_OUT_HI;
            end else begin
               div_d = div_q - 4'd1;
            end
         end
         S_OUT_HI: begin
            if (div_q == 4'd0) begin
               sclk_d = 1'b0;
               div_d  = DIV_RELOAD;
               if (bit_q != 3'd0) begin
                  bit_d   = bit_q - 3'd1;
                  shift_d = {shift_q[6:0], 1'b0};
                  sdo_d   = shift_q[6];
                  state_d = S_OUT_LO;
               end else if (cmd_idx_q != N_CMD) begin
                  state_d = S_CMD;
               end else begin
                  sdo_d      = 1'b0;
                  bit_d      = 3'd7;
                  byte_cnt_d = '0;
                  state_d    = S_IN_LO;
               end
            end else begin
               div_d = div_q - 4'd1;
            end
         end
         S_IN_LO: begin
            if (div_q == 4'd0) begin
               sclk_d  = 1'b1;
               shift_d = {shift_q[6:0], bus.spi_di_i};
               div_d   = DIV_RELOAD;
               state_d = S_IN_HI;
            end else begin
               div_d = div_q - 4'd1;
            end
         end
         S_IN_HI: begin
            if (div_q == 4'd0) begin
               sclk_d = 1'b0;
               div_d  = DIV_RELOAD;
               if (bit_q == 3'd0) begin
                  state_d = S_STORE;
               end else begin
                  bit_d   = bit_q - 3'd1;
                  state_d = S_IN_LO;
               end
            end else begin
               div_d = div_q - 4'd1;
            end
         end
         S_STORE: begin
            byte_cnt_d = byte_cnt_q + 1'b1;
            bit_d      = 3'd7;
            div_d      = DIV_RELOAD;
            state_d    = (byte_cnt_q == CNT_LAST) ? S_FINISH : S_IN_LO;
         end
         default: begin
            tags_d[victim_q]  = fill_tag_q;
            valid_d[victim_q] = 1'b1;
            ptr_d             = (ptr_q == SW'(SLOTS - 1)) ? '0 : ptr_q + 1'b1;
            cs_d              = 1'b1;
            sclk_d            = 1'b0;
            state_d           = S_IDLE;
         end
      endcase
   end

   // Control and status registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= S_IDLE;
         for (int s = 0; s < NS; s++) tags_q[s] <= '0;
         valid_q    <= '0;
         ptr_q      <= '0;
         victim_q   <= '0;
         fill_tag_q <= '0;
         div_q      <= '0;
         bit_q      <= '0;
         cmd_idx_q  <= '0;
         shift_q    <= '0;
         byte_cnt_q <= '0;
         data_out_q <= '0;
         busy_q     <= 1'b0;
         cs_q       <= 1'b1;
         sclk_q     <= 1'b0;
         sdo_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         tags_q     <= tags_d;
         valid_q    <= valid_d;
         ptr_q      <= ptr_d;
         victim_q   <= victim_d;
         fill_tag_q <= fill_tag_d;
         div_q      <= div_d;
         bit_q      <= bit_d;
         cmd_idx_q  <= cmd_idx_d;
         shift_q    <= shift_d;
         byte_cnt_q <= byte_cnt_d;
         data_out_q <= data_out_d;
         busy_q     <= busy_d;
         cs_q       <= cs_d;
         sclk_q     <= sclk_d;
         sdo_q      <= sdo_d;
      end
   end

   // Page storage; contents only matter once the slot is marked valid.
   always_ff @(posedge clk) begin
      if (state_q == S_STORE) mem_q[{victim_q, byte_cnt_q}] <= shift_q;
   end

   assign bus.data_out_o    = data_out_q;
   assign bus.busy_o        = busy_q;
   assign bus.spi_cs_o      = cs_q;
   assign bus.spi_clk_o     = sclk_q;
   assign bus.spi_do_o      = sdo_q;
   assign bus.flash_reset_o = ~reset;
   assign bus.flash_wp_o    = 1'b1;
endmodule

// File: tb/tb_flash_page_cache.sv
// Directed bench: two cache instances, each talking to a behavioural SPI flash.
module tb_flash_page_cache;
   logic clk = 1'b0;
   logic reset_a, reset_b;
   always #5 clk = ~clk;

   flash_page_cache_if if_a ();
   flash_page_cache_if if_b ();

   flash_page_cache #(.PAGE_BITS(8), .SLOTS(2), .CLK_DIV(1), .FAST_READ(0))
      dut_a (.clk(clk), .reset(reset_a), .bus(if_a.slave));
   flash_page_cache #(.PAGE_BITS(8), .SLOTS(1), .CLK_DIV(3), .FAST_READ(1))
      dut_b (.clk(clk), .reset(reset_b), .bus(if_b.slave));

   int passes = 0;
   int checks = 0;

   function automatic logic [7:0] fdat(input logic [23:0] a);
      return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'hA5;
   endfunction

   // Flash model A: 32 command bits, then data shifted out on falling spi_clk.
   int a_bits = 0, a_fills = 0, a_last_bits = 0, a_i;
   logic [39:0] a_sr = '0;
   logic [7:0]  a_last_op, a_d;
   logic [23:0] a_last_addr;
   always @(negedge if_a.spi_cs_o) begin a_bits = 0; a_fills++; end
   always @(posedge if_a.spi_cs_o) begin
      a_last_bits = a_bits; a_last_op = a_sr[31:24]; a_last_addr = a_sr[23:0];
   end
   always @(posedge if_a.spi_clk_o) if (if_a.spi_cs_o === 1'b0) begin
      if (a_bits < 32) a_sr = {a_sr[38:0], if_a.spi_do_o};
      a_bits++;
   end
   always @(negedge if_a.spi_clk_o) if (if_a.spi_cs_o === 1'b0 && a_bits >= 32) begin
      a_i = a_bits - 32;
      a_d = fdat(a_sr[23:0] + 24'(a_i / 8));
      if_a.spi_di_i = a_d[7 - (a_i % 8)];
   end

   // Flash model B: fast read, 40 command bits including the dummy byte.
   int b_bits = 0, b_fills = 0, b_last_bits = 0, b_i;
   logic [39:0] b_sr = '0;
   logic [7:0]  b_last_op, b_last_dummy, b_d;
   logic [23:0] b_last_addr;
   always @(negedge if_b.spi_cs_o) begin b_bits = 0; b_fills++; end
   always @(posedge if_b.spi_cs_o) begin
      b_last_bits = b_bits; b_last_op = b_sr[39:32];
      b_last_addr = b_sr[31:8]; b_last_dummy = b_sr[7:0];
   end
   always @(posedge if_b.spi_clk_o) if (if_b.spi_cs_o === 1'b0) begin
      if (b_bits < 40) b_sr = {b_sr[38:0], if_b.spi_do_o};
      b_bits++;
   end
   always @(negedge if_b.spi_clk_o) if (if_b.spi_cs_o === 1'b0 && b_bits >= 40) begin
      b_i = b_bits - 40;
      b_d = fdat(b_sr[31:8] + 24'(b_i / 8));
      if_b.spi_di_i = b_d[7 - (b_i % 8)];
   end

   // spi_clk phase lengths of instance B, in clk cycles.
   int b_run = 0, b_hi_min = 999, b_hi_max = 0, b_lo_min = 999;
   logic b_prev = 1'b0;
   always @(negedge clk) begin
      if (if_b.spi_cs_o === 1'b0) begin
         if (if_b.spi_clk_o === b_prev) begin
            b_run++;
         end else begin
            if (b_prev) begin
               if (b_run < b_hi_min) b_hi_min = b_run;
               if (b_run > b_hi_max) b_hi_max = b_run;
            end else if (b_run < b_lo_min) begin
               b_lo_min = b_run;
            end
            b_run  = 1;
            b_prev = if_b.spi_clk_o;
         end
      end else begin
         b_run  = 0;
         b_prev = 1'b0;
      end
   end

   task automatic chk(input string tag, input logic [39:0] obs, input logic [39:0] exp);
      checks++;
      assert (obs === exp) passes++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic wait_a_idle(input string tag, input int max);
      int n = 0;
      while (if_a.busy_o !== 1'b0 && n < max) begin @(negedge clk); n++; end
      chk(tag, 40'(n < max), 40'd1);
   endtask

   task automatic read_a(input string tag, input logic [23:0] addr);
      if_a.address_i = addr;
      cyc(1);
      chk({tag, "_busy"}, 40'(if_a.busy_o), 40'd0);
      chk({tag, "_data"}, 40'(if_a.data_out_o), 40'(fdat(addr)));
   endtask

   task automatic fill_a(input string tag, input logic [23:0] addr);
      if_a.address_i = addr;
      if_a.enable_i  = 1'b1;
      cyc(1);
      chk({tag, "_miss"}, 40'(if_a.busy_o), 40'd1);
      wait_a_idle({tag, "_done"}, 20000);
      chk({tag, "_bits"}, 40'(a_last_bits), 40'd2080);
      chk({tag, "_data"}, 40'(if_a.data_out_o), 40'(fdat(addr)));
   endtask

   initial begin
      int n, bad, fills_before;
      reset_a = 1'b1; reset_b = 1'b1;
      if_a.address_i = 24'h0; if_a.enable_i = 1'b0; if_a.spi_di_i = 1'b0;
      if_b.address_i = 24'h0ABCDE; if_b.enable_i = 1'b1; if_b.spi_di_i = 1'b0;
      cyc(3);
      chk("rst_busy", 40'(if_a.busy_o), 40'd0);
      chk("rst_cs", 40'(if_a.spi_cs_o), 40'd1);
      chk("rst_sclk", 40'(if_a.spi_clk_o), 40'd0);
      chk("rst_sdo", 40'(if_a.spi_do_o), 40'd0);
      chk("rst_dout", 40'(if_a.data_out_o), 40'd0);
      chk("rst_flash_reset", 40'(if_a.flash_reset_o), 40'd0);
      chk("wp", 40'(if_a.flash_wp_o), 40'd1);
      reset_a = 1'b0; reset_b = 1'b0;
      cyc(1);
      chk("post_rst_miss", 40'(if_a.busy_o), 40'd1);
      chk("flash_reset_hi", 40'(if_a.flash_reset_o), 40'd1);

      // Miss with enable low: no SPI traffic for 50 cycles.
      if_a.address_i = 24'h012345;
      bad = 0;
      repeat (50) begin
         cyc(1);
         if (if_a.spi_cs_o !== 1'b1 || if_a.busy_o !== 1'b1) bad++;
      end
      chk("en0_quiet", 40'(bad), 40'd0);
      chk("en0_no_fill", 40'(a_fills), 40'd0);
      if_a.enable_i = 1'b1;
      cyc(1);
      chk("en1_cs_low", 40'(if_a.spi_cs_o), 40'd0);
      wait_a_idle("fill1_done", 20000);
      chk("fill1_op", 40'(a_last_op), 40'h03);
      chk("fill1_addr", 40'(a_last_addr), 40'h012300);
      chk("fill1_bits", 40'(a_last_bits), 40'd2080);
      chk("fill1_data", 40'(if_a.data_out_o), 40'hC2);
      chk("fill1_cs_hi", 40'(if_a.spi_cs_o), 40'd1);
      if_a.address_i = 24'h0123FF;
      cyc(1);
      chk("hit_ff_data", 40'(if_a.data_out_o), 40'h78);
      chk("hit_ff_nofill", 40'(a_fills), 40'd1);

      // Reset at byte 100 of a fill aborts it; the page must be refetched.
      if_a.address_i = 24'h045600;
      cyc(1);
      n = 0;
      while (a_bits < 32 + 800 && n < 5000) begin cyc(1); n++; end
      chk("reach_byte100", 40'(n < 5000), 40'd1);
      reset_a = 1'b1;
      cyc(1);
      chk("abort_cs", 40'(if_a.spi_cs_o), 40'd1);
      chk("abort_sclk", 40'(if_a.spi_clk_o), 40'd0);
      chk("abort_busy", 40'(if_a.busy_o), 40'd0);
      reset_a = 1'b0;
      fill_a("refetch", 24'h045678);
      chk("refetch_addr", 40'(a_last_addr), 40'h045600);
      if_a.enable_i  = 1'b0;
      if_a.address_i = 24'h012345;
      cyc(1);
      chk("old_page_gone", 40'(if_a.busy_o), 40'd1);

      // Two resident pages, then round-robin eviction of the older one.
      reset_a = 1'b1;
      cyc(1);
      reset_a = 1'b0;
      fill_a("pg1", 24'h001ABC);
      fill_a("pg2", 24'h002ABC);
      fills_before = a_fills;
      read_a("hit_pg1", 24'h001ABC);
      read_a("hit_pg2", 24'h002A00);
      cyc(3);
      chk("hit_no_cs", 40'(a_fills), 40'(fills_before));
      fill_a("pg3", 24'h003ABC);
      if_a.enable_i  = 1'b0;
      if_a.address_i = 24'h001A00;
      cyc(1);
      chk("evicted_pg1", 40'(if_a.busy_o), 40'd1);
      chk("evicted_cs", 40'(if_a.spi_cs_o), 40'd1);
      read_a("kept_pg2", 24'h002A55);
      read_a("hit_pg3", 24'h003A00);

      // Address change mid-fill is ignored; the new address then misses.
      if_a.address_i = 24'h004400;
      if_a.enable_i  = 1'b1;
      cyc(20);
      if_a.address_i = 24'h0123FF;
      n = 0;
      while (if_a.spi_cs_o !== 1'b1 && n < 20000) begin cyc(1); n++; end
      chk("midfill_end", 40'(n < 20000), 40'd1);
      chk("midfill_addr", 40'(a_last_addr), 40'h004400);
      chk("midfill_bits", 40'(a_last_bits), 40'd2080);
      n = 0;
      while (if_a.spi_cs_o !== 1'b0 && n < 5) begin cyc(1); n++; end
      chk("refill_start", 40'(n < 5), 40'd1);
      wait_a_idle("refill_done", 20000);
      chk("refill_addr", 40'(a_last_addr), 40'h012300);
      chk("refill_data", 40'(if_a.data_out_o), 40'(fdat(24'h0123FF)));

      // Fast-read instance, running alongside since reset.
      n = 0;
      while (if_b.busy_o !== 1'b0 && n < 20000) begin cyc(1); n++; end
      chk("b_done", 40'(n < 20000), 40'd1);
      chk("b_op", 40'(b_last_op), 40'h0B);
      chk("b_addr", 40'(b_last_addr), 40'h0ABC00);
      chk("b_dummy", 40'(b_last_dummy), 40'h00);
      chk("b_bits", 40'(b_last_bits), 40'd2088);
      chk("b_fills", 40'(b_fills), 40'd1);
      chk("b_data", 40'(if_b.data_out_o), 40'hCD);
      chk("b_hi_min", 40'(b_hi_min), 40'd3);
      chk("b_hi_max", 40'(b_hi_max), 40'd3);
      chk("b_lo_min", 40'(b_lo_min), 40'd3);

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end
endmodule

// File: doc/flash_page_cache.md
FLASH_PAGE_CACHE -- requirements
Module: flash_page_cache

Interface
REQ-001 Parameter PAGE_BITS, default 12, meaning log2 of page size in bytes; legal range 8..12.
REQ-002 Parameter SLOTS, default 2, meaning number of resident page slots; legal values 1, 2, 4.
REQ-003 Parameter CLK_DIV, default 1, meaning clk cycles per SPI clock half-period; legal range 1..15.
REQ-004 Parameter FAST_READ, default 0, meaning 0 selects opcode 0x03 and 1 selects opcode 0x0B with one dummy byte.
REQ-005 clk  input  1  system clock; all logic on the rising edge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 address  input  24  byte address in flash space.
REQ-008 enable  input  1  permits a page fill to start on a miss.
REQ-009 data_out  output  8  registered read data.
REQ-010 busy  output  1  high while the addressed page is not resident.
REQ-011 spi_cs  output  1  flash chip select, active low.
REQ-012 spi_clk  output  1  SPI clock, idle low (mode 0).
REQ-013 spi_do  output  1  serial data to the flash.
REQ-014 spi_di  input  1  serial data from the flash.
REQ-015 flash_reset  output  1  equals ~reset.
REQ-016 flash_wp  output  1  constant 1, write-protected.

Function
REQ-017 Tag = address[23:PAGE_BITS]; hit = any slot with valid=1 and stored tag equal to tag.
REQ-018 On hit in IDLE: data_out <= slot RAM[address[PAGE_BITS-1:0]] one cycle later; busy <= 0.
REQ-019 On miss: busy <= 1 on the next edge; data_out holds its last value.
REQ-020 On miss with enable=1 in IDLE: latch address, pick victim = round-robin pointer, clear victim valid, drive spi_cs <= 0, enter CMD.
REQ-021 On miss with enable=0: stay in IDLE, busy=1, no SPI activity.
REQ-022 Command bytes are sent MSB first in this order: opcode, A[23:16], A[15:8], A[7:0], with A = latched address and A[PAGE_BITS-1:0] forced to 0; when FAST_READ=1, one 0x00 dummy byte follows.
REQ-023 Per bit: spi_do is updated with spi_clk low, held low CLK_DIV cycles, then spi_clk is driven high CLK_DIV cycles.
REQ-024 Read phase: spi_do=0; spi_di is sampled on the clk edge that drives spi_clk high; bytes assemble MSB first.
REQ-025 Each completed byte is written to victim RAM at a byte counter starting at 0; the fill ends after 2^PAGE_BITS bytes.
REQ-026 States: IDLE -> CMD (load next byte) -> OUT_LO -> OUT_HI -> (next bit | CMD | IN_LO) -> IN_LO -> IN_HI -> STORE -> (IN_LO | FINISH) -> IDLE.
REQ-027 FINISH: store the tag, set valid, advance the round-robin pointer modulo SLOTS, spi_cs <= 1, spi_clk <= 0.
REQ-028 After FINISH, a hit resolves via REQ-018 with no extra wait beyond one cycle.
REQ-029 Address changes during a fill are ignored until FINISH; a miss then starts a new fill.
REQ-030 The counter wraps only at 2^PAGE_BITS-1; no partial page is ever marked valid.
REQ-031 Two slots can never hold the same tag.

Reset
REQ-032 Reset values: all valid=0, pointer=0, state=IDLE, busy=0, spi_cs=1, spi_clk=0, spi_do=0, data_out=0.
REQ-033 Reset during a fill aborts it within one cycle: spi_cs=1, and the victim stays invalid.
REQ-034 In the first cycle after reset deasserts, any address is a miss.

Verification
REQ-035 After reset, address=0x012345 with enable=1 -> opcode 0x03 then bytes 0x01, 0x20, 0x00 on spi_do; 4096 bytes clocked in; busy falls; data_out = flash[0x012345].
REQ-036 With SLOTS=2, fill pages 0x001 and 0x002, then read 0x001ABC -> hit, no spi_cs low, data valid after 1 cycle.
REQ-037 With SLOTS=2, a third page 0x003 -> evicts slot 0 (page 0x001); a later access to 0x001000 misses.
REQ-038 With FAST_READ=1, CLK_DIV=3, PAGE_BITS=8 -> opcode 0x0B, dummy 0x00, spi_clk high/low 3 cycles each, 256 bytes read.
REQ-039 Assert reset at byte 100 of a fill -> spi_cs=1 next cycle; a re-access refetches the full page.
REQ-040 Miss with enable=0 for 50 cycles -> busy=1, spi_cs stays 1; raising enable starts the fill.
